// File: rtl/fft_unload_ctrl.sv
// Unloads N_POINTS FFT results from DMEM in natural order and streams them out
// over valid/ready, with a credit-managed FWFT FIFO absorbing read latency.
module fft_unload_ctrl #(
  parameter int N_POINTS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fft_done,
  input  logic              final_bank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank_sel,
  input  logic [DATA_W-1:0] rd_real,
  input  logic [DATA_W-1:0] rd_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              unload_done,
  output logic              overrun
);

  localparam int DEPTH = READ_LAT + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_POINTS - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic [READ_LAT-1:0] pipe_v;
  logic [ADDR_W-1:0]   pipe_idx [READ_LAT];

  logic [DATA_W-1:0] fifo_real [DEPTH];
  logic [DATA_W-1:0] fifo_imag [DEPTH];
  logic [ADDR_W-1:0] fifo_idx  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic [CNT_W-1:0] inflight;
  logic [CNT_W:0]   occupancy;
  logic             push, pop, credit_ok, issue, head_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < READ_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_v[i]);
    end
  end

  assign push      = pipe_v[READ_LAT-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  // A word popped this cycle frees its slot in time for a read issued now.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight} - {{CNT_W{1'b0}}, pop};
  assign credit_ok = occupancy < (CNT_W + 1)'(DEPTH);
  assign issue     = (state == ISSUE) && credit_ok;
  assign rd_en     = issue;
  assign head_last = (fifo_idx[rd_ptr] == LAST_ADDR);

  assign out_real  = out_valid ? fifo_real[rd_ptr] : '0;
  assign out_imag  = out_valid ? fifo_imag[rd_ptr] : '0;
  assign out_index = out_valid ? fifo_idx[rd_ptr]  : '0;
  assign out_last  = out_valid && head_last;

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    unload_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (fft_done) state_next = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (issue && rd_addr == LAST_ADDR) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && head_last && fifo_count == CNT_W'(1) && inflight == '0)
          state_next = DONE;
      end
      DONE: begin
        unload_done = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rd_addr     <= '0;
      rd_bank_sel <= 1'b0;
      overrun     <= 1'b0;
      pipe_v      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && fft_done) begin
        rd_bank_sel <= final_bank;
        rd_addr     <= '0;
      end
      if (fft_done && state != IDLE) overrun <= 1'b1;
      // Address parks on the last bin once it has been issued.
      if (issue && rd_addr != LAST_ADDR) rd_addr <= rd_addr + 1'b1;

      pipe_v[0] <= issue;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
      end

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    pipe_idx[0] <= rd_addr;
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      pipe_idx[i] <= pipe_idx[i-1];
    end
    if (push) begin
      fifo_real[wr_ptr] <= rd_real;
      fifo_imag[wr_ptr] <= rd_imag;
      fifo_idx[wr_ptr]  <= pipe_idx[READ_LAT-1];
    end
  end

endmodule

// File: tb/tb_fft_unload_ctrl.sv
// Bench for fft_unload_ctrl: READ_LAT=1 and READ_LAT=3 instances share stimulus;
// a per-instance scoreboard tracks every expected word.
module tb_fft_unload_ctrl;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [4:0]  idx;
    logic        last;
  } word_t;

  typedef struct {
    bit bank;
    bit rand_ready;
    int pulse_idx;
    bit exp_overrun;
  } vec_t;

  logic clock = 1'b0;
  logic reset, fft_done, final_bank, out_ready;

  logic        rd_en_s [2];
  logic [4:0]  rd_addr_s [2];
  logic        rd_bank_sel_s [2];
  logic [15:0] rd_real_s [2];
  logic [15:0] rd_imag_s [2];
  logic        out_valid_s [2];
  logic [15:0] out_real_s [2];
  logic [15:0] out_imag_s [2];
  logic [4:0]  out_index_s [2];
  logic        out_last_s [2];
  logic        busy_s [2];
  logic        unload_done_s [2];
  logic        overrun_s [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_on = 0;
  bit ready_all = 0;

  word_t sbq0[$];
  word_t sbq1[$];
  bit    held [2];
  word_t held_w [2];
  bit    expect_done [2];
  bit    done_seen [2];
  bit    seen_rd [2];
  bit    seen_ov [2];
  int    first_rd [2];
  int    first_ov [2];
  int    exp_addr [2];
  bit    exp_bank [2];
  int    lat [2] = '{1, 3};

  always #5 clock = ~clock;

  fft_unload_ctrl #(.N_POINTS(32), .ADDR_W(5), .DATA_W(16), .READ_LAT(1)) u_lat1 (
    .clock(clock), .reset(reset), .fft_done(fft_done), .final_bank(final_bank),
    .rd_en(rd_en_s[0]), .rd_addr(rd_addr_s[0]), .rd_bank_sel(rd_bank_sel_s[0]),
    .rd_real(rd_real_s[0]), .rd_imag(rd_imag_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready),
    .out_real(out_real_s[0]), .out_imag(out_imag_s[0]),
    .out_index(out_index_s[0]), .out_last(out_last_s[0]),
    .busy(busy_s[0]), .unload_done(unload_done_s[0]), .overrun(overrun_s[0])
  );

  fft_unload_ctrl #(.N_POINTS(32), .ADDR_W(5), .DATA_W(16), .READ_LAT(3)) u_lat3 (
    .clock(clock), .reset(reset), .fft_done(fft_done), .final_bank(final_bank),
    .rd_en(rd_en_s[1]), .rd_addr(rd_addr_s[1]), .rd_bank_sel(rd_bank_sel_s[1]),
    .rd_real(rd_real_s[1]), .rd_imag(rd_imag_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready),
    .out_real(out_real_s[1]), .out_imag(out_imag_s[1]),
    .out_index(out_index_s[1]), .out_last(out_last_s[1]),
    .busy(busy_s[1]), .unload_done(unload_done_s[1]), .overrun(overrun_s[1])
  );

  function automatic logic [31:0] dmem(input logic bank, input logic [4:0] a);
    if (bank) return {16'h0100 + 16'(a), 16'hF000 + 16'(a)};
    return {16'h8000 + 16'(a) * 16'd3, 16'h7FFF - 16'(a)};
  endfunction

  // DMEM models; non-read cycles return a poison value.
  logic [31:0] m0, m1a, m1b, m1c;
  always_ff @(posedge clock) begin
    m0  <= rd_en_s[0] ? dmem(rd_bank_sel_s[0], rd_addr_s[0]) : 32'hDEADBEEF;
    m1a <= rd_en_s[1] ? dmem(rd_bank_sel_s[1], rd_addr_s[1]) : 32'hDEADBEEF;
    m1b <= m1a;
    m1c <= m1b;
  end
  assign rd_real_s[0] = m0[31:16];
  assign rd_imag_s[0] = m0[15:0];
  assign rd_real_s[1] = m1c[31:16];
  assign rd_imag_s[1] = m1c[15:0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor_one(input int i);
    word_t w, e;
    logic v;
    v = out_valid_s[i];
    w = {out_real_s[i], out_imag_s[i], out_index_s[i], out_last_s[i]};
    if (held[i]) chk($sformatf("stall_hold[%0d]", i), {v, w}, {1'b1, held_w[i]});
    if (v && out_ready) begin
      if ((i == 0 && sbq0.size() == 0) || (i == 1 && sbq1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL extra_word[%0d]: got %0h expected no word", i, w);
      end else begin
        e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
        chk($sformatf("word[%0d]", i), w, e);
      end
      if (w.last && ready_all)
        chk($sformatf("throughput[%0d]", i), cyc - first_ov[i], 31);
    end
    if (expect_done[i])
      chk($sformatf("done_pulse[%0d]", i), {unload_done_s[i], busy_s[i]}, 2'b10);
    else
      chk($sformatf("no_done[%0d]", i), unload_done_s[i], 0);
    if (unload_done_s[i]) done_seen[i] = 1;
    if (rd_en_s[i]) begin
      chk($sformatf("rd_addr[%0d]", i), {rd_bank_sel_s[i], rd_addr_s[i]},
          {exp_bank[i], 5'(exp_addr[i])});
      if (!seen_rd[i]) begin
        seen_rd[i]  = 1;
        first_rd[i] = cyc;
      end
      if (ready_all && exp_addr[i] == 31)
        chk($sformatf("issue_burst[%0d]", i), cyc - first_rd[i], 31);
      exp_addr[i]++;
    end
    if (v && !seen_ov[i]) begin
      seen_ov[i]  = 1;
      first_ov[i] = cyc;
      chk($sformatf("first_latency[%0d]", i), cyc - first_rd[i], lat[i] + 1);
    end
    held[i]        = v && !out_ready;
    held_w[i]      = w;
    expect_done[i] = v && out_ready && w.last;
  endtask

  task automatic tick();
    #1;
    if (mon_on) begin
      monitor_one(0);
      monitor_one(1);
      chk("fifo_bound[0]", u_lat1.fifo_count <= 3, 1);
      chk("fifo_bound[1]", u_lat3.fifo_count <= 5, 1);
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic clear_tracking();
    sbq0.delete();
    sbq1.delete();
    for (int i = 0; i < 2; i++) begin
      held[i] = 0;
      expect_done[i] = 0;
      done_seen[i] = 0;
      seen_rd[i] = 0;
      seen_ov[i] = 0;
    end
  endtask

  task automatic check_zero(input string name);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s[%0d]", name, i),
          {rd_en_s[i], rd_addr_s[i], rd_bank_sel_s[i], out_valid_s[i], out_real_s[i],
           out_imag_s[i], out_index_s[i], out_last_s[i], busy_s[i], unload_done_s[i],
           overrun_s[i]}, 0);
  endtask

  task automatic start_frame(input bit bank);
    word_t e;
    for (int k = 0; k < 32; k++) begin
      {e.re, e.im} = dmem(bank, 5'(k));
      e.idx  = 5'(k);
      e.last = (k == 31);
      sbq0.push_back(e);
      sbq1.push_back(e);
    end
    for (int i = 0; i < 2; i++) begin
      exp_addr[i] = 0;
      exp_bank[i] = bank;
      done_seen[i] = 0;
      seen_rd[i] = 0;
      seen_ov[i] = 0;
    end
    fft_done   = 1;
    final_bank = bank;
    tick();
    fft_done = 0;
    for (int i = 0; i < 2; i++)
      chk($sformatf("frame_start[%0d]", i), {busy_s[i], rd_en_s[i], rd_bank_sel_s[i]},
          {2'b11, bank});
  endtask

  task automatic run_frame(input bit bank, input bit rand_ready, input int pulse_idx);
    bit pulsed = 0;
    ready_all = !rand_ready;
    out_ready = 1;
    start_frame(bank);
    for (int n = 0; n < 600; n++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulse_idx >= 0 && !pulsed && out_valid_s[0] && out_index_s[0] == 5'(pulse_idx)) begin
        fft_done   = 1;
        final_bank = !bank;
        pulsed     = 1;
      end else begin
        fft_done = 0;
      end
      tick();
      if (done_seen[0] && done_seen[1]) break;
    end
    fft_done = 0;
    chk("frame_complete", {done_seen[0], done_seen[1]}, 2'b11);
    chk("queues_empty", sbq0.size() + sbq1.size(), 0);
    out_ready = 1;
    tick();
    tick();
  endtask

  initial begin
    vec_t tbl[4];
    tbl[0] = '{bank: 1'b1, rand_ready: 1'b0, pulse_idx: -1, exp_overrun: 1'b0};
    tbl[1] = '{bank: 1'b1, rand_ready: 1'b1, pulse_idx: -1, exp_overrun: 1'b0};
    tbl[2] = '{bank: 1'b0, rand_ready: 1'b0, pulse_idx: 5,  exp_overrun: 1'b1};
    tbl[3] = '{bank: 1'b1, rand_ready: 1'b1, pulse_idx: -1, exp_overrun: 1'b1};

    clear_tracking();
    reset = 1;
    fft_done = 1;
    final_bank = 1;
    out_ready = 1;
    tick();
    mon_on = 1;
    tick();
    tick();
    check_zero("reset_state");
    reset = 0;
    fft_done = 0;
    tick();
    check_zero("post_reset_idle");

    for (int t = 0; t < 4; t++) begin
      run_frame(tbl[t].bank, tbl[t].rand_ready, tbl[t].pulse_idx);
      for (int i = 0; i < 2; i++)
        chk($sformatf("overrun_row%0d[%0d]", t, i), overrun_s[i], tbl[t].exp_overrun);
    end

    // Mid-frame reset once bin 10 is at the head of the fast instance.
    ready_all = 1;
    out_ready = 1;
    start_frame(1'b1);
    for (int n = 0; n < 100; n++) begin
      if (out_valid_s[0] && out_index_s[0] == 5'd10) break;
      tick();
    end
    chk("reached_bin10", {out_valid_s[0], out_index_s[0]}, {1'b1, 5'd10});
    reset = 1;
    tick();
    check_zero("midframe_reset");
    reset = 0;
    clear_tracking();
    tick();
    check_zero("after_reset_idle");
    run_frame(1'b0, 1'b0, -1);
    for (int i = 0; i < 2; i++)
      chk($sformatf("overrun_cleared[%0d]", i), overrun_s[i], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
